// File: rtl/spi_ram_arbiter_if.sv
// Request/response channel between one master and the SPI RAM arbiter.
// The master drives a whole read or write transaction with a valid/ready
// handshake. The arbiter returns a one-cycle response pulse carrying read
// data and the timeout error flag.
interface spi_ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [ADDR_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic [ADDR_SIZE-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Two-master arbiter for the single-command-port RAM.
// Whole transactions from m0 and m1 are granted round-robin. Each transaction
// is expanded into RAM command words (opcode in the top two bits). The write
// acknowledge or the read data is returned to the master that issued it.
// Optional read watchdog: define SPI_RAM_ARB_TIMEOUT_EN. When it is enabled,
// a read that sees no ram_tx_valid for TIMEOUT cycles completes with rsp_err.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_ram_arbiter_if.slave     m0,
  spi_ram_arbiter_if.slave     m1,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RDCMD, S_WAIT_RD} state_e;

  localparam logic [1:0] OP_WRITE_ADDR = 2'b00;
  localparam logic [1:0] OP_WRITE_DATA = 2'b01;
  localparam logic [1:0] OP_READ_ADDR  = 2'b10;
  localparam logic [1:0] OP_READ_DATA  = 2'b11;

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;        // master preferred on a tie
  logic                 owner_q, owner_d;  // master of the transaction in flight
  logic                 wr_q, wr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE+1:0] din_q, din_d;
  logic                 rx_q, rx_d;
  logic [1:0]           rsp_valid_q, rsp_valid_d;
  logic [ADDR_SIZE-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]           ready;
  logic                 gnt;
  logic                 rsp_fire;
  logic [ADDR_SIZE-1:0] rsp_data;

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic             rsp_err_now;
`endif

  // Arbitration, command-word sequencing and response generation.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    din_d       = din_q;
    rx_d        = 1'b0;
    rsp_valid_d = '0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ready       = '0;
    gnt         = 1'b0;
    rsp_fire    = 1'b0;
    rsp_data    = '0;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = '0;
    rsp_err_now = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (m0.req_valid || m1.req_valid) begin
          gnt        = (m0.req_valid && m1.req_valid) ? rr_q : m1.req_valid;
          ready[gnt] = 1'b1;
          owner_d    = gnt;
          rr_d       = ~gnt;
          wr_d       = gnt ? m1.req_wr    : m0.req_wr;
          addr_d     = gnt ? m1.req_addr  : m0.req_addr;
          wdata_d    = gnt ? m1.req_wdata : m0.req_wdata;
          din_d      = {wr_d ? OP_WRITE_ADDR : OP_READ_ADDR, addr_d};
          rx_d       = 1'b1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        rx_d = 1'b1;
        if (wr_q) begin
          din_d   = {OP_WRITE_DATA, wdata_q};
          state_d = S_WDATA;
        end else begin
          din_d   = {OP_READ_DATA, {ADDR_SIZE{1'b0}}};
          state_d = S_RDCMD;
        end
      end
      S_WDATA: begin
        rsp_fire = 1'b1;
        state_d  = S_IDLE;
      end
      S_RDCMD: begin
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (ram_tx_valid) begin
          rsp_fire = 1'b1;
          rsp_data = ram_dout;
          state_d  = S_IDLE;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_fire    = 1'b1;
          rsp_err_now = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Responses always go to the owner only, so both masters never pulse together.
    if (rsp_fire) begin
      rsp_valid_d[owner_q] = 1'b1;
      if (owner_q) rdata1_d = rsp_data;
      else         rdata0_d = rsp_data;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
      rsp_err_d[owner_q] = rsp_err_now;
`endif
    end
  end

  // State, captured transaction and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      din_q       <= '0;
      rx_q        <= 1'b0;
      rsp_valid_q <= '0;
      // NOTE: the held read-data registers are reset too, because the master sees them directly as outputs.
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      din_q       <= din_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  // Read watchdog counter and the error flag that goes with each response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rsp_err_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign m0.rsp_err = rsp_err_q[0];
  assign m1.rsp_err = rsp_err_q[1];
`else
  assign m0.rsp_err = 1'b0;
  assign m1.rsp_err = 1'b0;
`endif

  assign m0.req_ready  = ready[0];
  assign m1.req_ready  = ready[1];
  assign m0.rsp_valid  = rsp_valid_q[0];
  assign m1.rsp_valid  = rsp_valid_q[1];
  assign m0.rsp_rdata  = rdata0_q;
  assign m1.rsp_rdata  = rdata1_q;
  assign ram_din       = din_q;
  assign ram_rx_valid  = rx_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter. A transaction-level model predicts
// grants, the command-word timeline and responses. The model is compared with
// the DUT on every cycle. Directed sequences pin the model to literal values.
module tb_spi_ram_arbiter;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       busy;

  spi_ram_arbiter_if #(.ADDR_SIZE(8)) m0_if ();
  spi_ram_arbiter_if #(.ADDR_SIZE(8)) m1_if ();

  spi_ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0           (m0_if),
    .m1           (m1_if),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Future events live in a small ring indexed by cycle number. An accepted
  // transaction schedules its two command words, and a write also schedules
  // its acknowledge. A read completes on the first tx_valid at or after its
  // wait start, or when the watchdog expires.
  bit         s_rx  [8];
  logic [9:0] s_din [8];
  bit   [1:0] s_rsp [8];
  logic [7:0] s_rd  [8];
  bit         s_err [8];

  int         mc = 0;
  bit         md_reading;
  bit         md_rr;
  bit         md_rd_owner;
  int         md_wait;
  int         md_free;
  logic [9:0] md_din;
  logic [7:0] md_rdata [2];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      s_rx[i] = 0; s_din[i] = '0; s_rsp[i] = '0; s_rd[i] = '0; s_err[i] = 0;
    end
    md_reading = 0; md_rr = 0; md_rd_owner = 0; md_wait = 0; md_free = 0;
    md_din = '0; md_rdata[0] = '0; md_rdata[1] = '0;
  endtask

  task automatic sched_cmd(input int c, input logic [9:0] w);
    s_rx[c % 8]  = 1;
    s_din[c % 8] = w;
  endtask

  task automatic sched_rsp(input int c, input bit who, input logic [7:0] d, input bit e);
    s_rsp[c % 8][who] = 1'b1;
    s_rd[c % 8]       = d;
    s_err[c % 8]      = e;
  endtask

  task automatic model_step();
    bit         idle;
    bit         g;
    logic       wr;
    logic [7:0] ad, wd;
    logic [1:0] er, ev, ee;
    bit         ex_rx;
    int         k;
    idle = !md_reading && (mc >= md_free);
    er   = '0;
    if (idle && (m0_if.req_valid || m1_if.req_valid)) begin
      g     = (m0_if.req_valid && m1_if.req_valid) ? md_rr : m1_if.req_valid;
      er[g] = 1'b1;
      md_rr = !g;
      wr = g ? m1_if.req_wr    : m0_if.req_wr;
      ad = g ? m1_if.req_addr  : m0_if.req_addr;
      wd = g ? m1_if.req_wdata : m0_if.req_wdata;
      sched_cmd(mc + 1, {wr ? 2'b00 : 2'b10, ad});
      if (wr) begin
        sched_cmd(mc + 2, {2'b01, wd});
        sched_rsp(mc + 3, g, 8'h00, 1'b0);
        md_free = mc + 3;
      end else begin
        sched_cmd(mc + 2, {2'b11, 8'h00});
        md_reading  = 1;
        md_wait     = mc + 3;
        md_rd_owner = g;
      end
    end else if (md_reading && mc >= md_wait) begin
      if (ram_tx_valid) begin
        sched_rsp(mc + 1, md_rd_owner, ram_dout, 1'b0);
        md_reading = 0;
        md_free    = mc + 1;
`ifdef SPI_RAM_ARB_TIMEOUT_EN
      end else if (mc - md_wait == TO - 1) begin
        sched_rsp(mc + 1, md_rd_owner, 8'h00, 1'b1);
        md_reading = 0;
        md_free    = mc + 1;
`endif
      end
    end
    k     = mc % 8;
    ex_rx = s_rx[k];
    if (ex_rx) md_din = s_din[k];
    ev = s_rsp[k];
    ee = '0;
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) begin
        md_rdata[i] = s_rd[k];
        ee[i]       = s_err[k];
      end
    end
    s_rx[k] = 0; s_rsp[k] = '0; s_err[k] = 0;

    check("m_ready0",  32'(m0_if.req_ready), 32'(er[0]));
    check("m_ready1",  32'(m1_if.req_ready), 32'(er[1]));
    check("m_rx",      32'(ram_rx_valid),    32'(ex_rx));
    check("m_din",     32'(ram_din),         32'(md_din));
    check("m_busy",    32'(busy),            32'(!idle));
    check("m_rsp0",    32'(m0_if.rsp_valid), 32'(ev[0]));
    check("m_rsp1",    32'(m1_if.rsp_valid), 32'(ev[1]));
    check("m_rdata0",  32'(m0_if.rsp_rdata), 32'(md_rdata[0]));
    check("m_rdata1",  32'(m1_if.rsp_rdata), 32'(md_rdata[1]));
    check("m_err0",    32'(m0_if.rsp_err),   32'(ee[0]));
    check("m_err1",    32'(m1_if.rsp_err),   32'(ee[1]));
  endtask

  // Model update and compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    mc++;
  end

  // ---------------- stimulus helpers ----------------
  bit seen_r0, seen_r1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    seen_r0 = m0_if.req_ready;
    seen_r1 = m1_if.req_ready;
  endtask

  task automatic rand_req(input bit who);
    if (who) begin
      m1_if.req_valid = 1; m1_if.req_wr = 1'($urandom_range(0, 1));
      m1_if.req_addr = 8'($urandom); m1_if.req_wdata = 8'($urandom);
    end else begin
      m0_if.req_valid = 1; m0_if.req_wr = 1'($urandom_range(0, 1));
      m0_if.req_addr = 8'($urandom); m0_if.req_wdata = 8'($urandom);
    end
  endtask

  // Randomized traffic: a request is dropped only after it was accepted.
  task automatic run_cycles(input int n, input bit new_reqs);
    for (int i = 0; i < n; i++) begin
      tick();
      if (m0_if.req_valid && seen_r0) m0_if.req_valid = 0;
      if (m1_if.req_valid && seen_r1) m1_if.req_valid = 0;
      if (new_reqs && !m0_if.req_valid && $urandom_range(0, 2) == 0) rand_req(1'b0);
      if (new_reqs && !m1_if.req_valid && $urandom_range(0, 2) == 0) rand_req(1'b1);
      ram_tx_valid = ($urandom_range(0, 3) == 0);
      ram_dout     = 8'($urandom);
      sample();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_din"},    32'(ram_din),         32'h0);
    check({tag, "_rx"},     32'(ram_rx_valid),    32'h0);
    check({tag, "_busy"},   32'(busy),            32'h0);
    check({tag, "_rdy0"},   32'(m0_if.req_ready), 32'h0);
    check({tag, "_rdy1"},   32'(m1_if.req_ready), 32'h0);
    check({tag, "_rsp0"},   32'(m0_if.rsp_valid), 32'h0);
    check({tag, "_rsp1"},   32'(m1_if.rsp_valid), 32'h0);
    check({tag, "_rdata0"}, 32'(m0_if.rsp_rdata), 32'h0);
    check({tag, "_rdata1"}, 32'(m1_if.rsp_rdata), 32'h0);
    check({tag, "_err0"},   32'(m0_if.rsp_err),   32'h0);
    check({tag, "_err1"},   32'(m1_if.rsp_err),   32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int ng;
  bit glog [8];

  initial begin
    rst_n = 1'b1;
    m0_if.req_valid = 0; m0_if.req_wr = 0; m0_if.req_addr = '0; m0_if.req_wdata = '0;
    m1_if.req_valid = 0; m1_if.req_wr = 0; m1_if.req_addr = '0; m1_if.req_wdata = '0;
    ram_tx_valid = 0; ram_dout = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Spurious tx_valid while idle.
    tick(); ram_tx_valid = 1; ram_dout = 8'h77; sample();
    tick(); ram_tx_valid = 0;

    // m0 write 0x12 <- 0xA5.
    m0_if.req_valid = 1; m0_if.req_wr = 1; m0_if.req_addr = 8'h12; m0_if.req_wdata = 8'hA5;
    sample();
    check("wr_ready0", 32'(m0_if.req_ready), 32'h1);
    check("wr_ready1", 32'(m1_if.req_ready), 32'h0);
    tick(); m0_if.req_valid = 0; sample();
    check("wr_din1", 32'(ram_din), 32'h012);
    check("wr_rx1",  32'(ram_rx_valid), 32'h1);
    tick(); ram_tx_valid = 1; ram_dout = 8'hFF; sample();
    check("wr_din2", 32'(ram_din), 32'h1A5);
    check("wr_rx2",  32'(ram_rx_valid), 32'h1);
    tick(); ram_tx_valid = 0; sample();
    check("wr_rsp0", 32'(m0_if.rsp_valid), 32'h1);
    check("wr_err0", 32'(m0_if.rsp_err), 32'h0);
    check("wr_rsp1", 32'(m1_if.rsp_valid), 32'h0);

    // m1 read 0x12, RAM answers 0xA5 at T+3.
    tick(); m1_if.req_valid = 1; m1_if.req_wr = 0; m1_if.req_addr = 8'h12; sample();
    check("rd_ready1", 32'(m1_if.req_ready), 32'h1);
    tick(); m1_if.req_valid = 0; sample();
    check("rd_din1", 32'(ram_din), 32'h212);
    tick(); sample();
    check("rd_din2", 32'(ram_din), 32'h300);
    tick(); ram_tx_valid = 1; ram_dout = 8'hA5; sample();
    check("rd_rx_wait", 32'(ram_rx_valid), 32'h0);
    check("rd_rsp_early", 32'(m1_if.rsp_valid), 32'h0);
    tick(); ram_tx_valid = 0; sample();
    check("rd_rsp1",   32'(m1_if.rsp_valid), 32'h1);
    check("rd_rdata1", 32'(m1_if.rsp_rdata), 32'hA5);
    check("rd_rsp0",   32'(m0_if.rsp_valid), 32'h0);

    // Both masters requesting continuously: grants alternate from m0.
    tick(); rand_req(1'b0); rand_req(1'b1);
    m0_if.req_wr = 1; m1_if.req_wr = 1;
    ng = 0;
    for (int i = 0; i < 40 && (m0_if.req_valid || m1_if.req_valid); i++) begin
      sample();
      if (seen_r0 || seen_r1) begin
        if (ng < 8) glog[ng] = seen_r1;
        ng++;
      end
      tick();
      if (seen_r0) begin
        if (ng < 4) begin rand_req(1'b0); m0_if.req_wr = 1; end
        else m0_if.req_valid = 0;
      end
      if (seen_r1) begin
        if (ng < 4) begin rand_req(1'b1); m1_if.req_wr = 1; end
        else m1_if.req_valid = 0;
      end
    end
    check("alt_total", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("alt_grant%0d", i), 32'(glog[i]), 32'(i % 2));
    repeat (4) begin tick(); sample(); end

    // Reset while a read sits in WAIT_RD.
    tick(); m0_if.req_valid = 1; m0_if.req_wr = 0; m0_if.req_addr = 8'h33; sample();
    tick(); m0_if.req_valid = 0; sample();
    repeat (3) begin tick(); sample(); end
    check("wait_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    sample();
    tick(); ram_tx_valid = 1; ram_dout = 8'h5A; sample();
    tick(); ram_tx_valid = 0; sample();
    check("late_rsp0", 32'(m0_if.rsp_valid), 32'h0);
    check("late_rsp1", 32'(m1_if.rsp_valid), 32'h0);
    tick(); rand_req(1'b0); rand_req(1'b1); sample();
    check("post_rst_gnt0", 32'(m0_if.req_ready), 32'h1);
    check("post_rst_gnt1", 32'(m1_if.req_ready), 32'h0);

    // Random traffic, then drain.
    run_cycles(1500, 1'b1);
    run_cycles(80, 1'b0);

`ifdef SPI_RAM_ARB_TIMEOUT_EN
    // Read with no RAM answer: error response 16 cycles after WAIT_RD entry.
    tick(); ram_tx_valid = 0;
    m0_if.req_valid = 1; m0_if.req_wr = 0; m0_if.req_addr = 8'h44; sample();
    check("to_ready0", 32'(m0_if.req_ready), 32'h1);
    tick(); m0_if.req_valid = 0; sample();
    for (int k = 2; k <= 18; k++) begin tick(); sample(); end
    check("to_early", 32'(m0_if.rsp_valid), 32'h0);
    tick(); sample();
    check("to_rsp0",   32'(m0_if.rsp_valid), 32'h1);
    check("to_err0",   32'(m0_if.rsp_err),   32'h1);
    check("to_rdata0", 32'(m0_if.rsp_rdata), 32'h00);
    check("to_busy",   32'(busy),            32'h0);
    tick(); sample();
    check("to_busy_next", 32'(busy), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
